// File: rtl/pipe_cla_pkg.sv
// Shared constants for the pipelined CLA adder/subtractor family.
package pipe_cla_pkg;

  localparam int unsigned DefaultWidth = 32;

  // Saturation bounds for the default width (max positive / min negative).
  localparam logic [DefaultWidth-1:0] SatMax = {1'b0, {(DefaultWidth-1){1'b1}}};
  localparam logic [DefaultWidth-1:0] SatMin = {1'b1, {(DefaultWidth-1){1'b0}}};

  // Flow control: a beat moves on valid & ready; s2_ready = ~out_valid | out_ready,
  // in_ready = ~s1_valid | s2_ready, both combinational so a full pipe refills in one cycle.

endpackage

// File: rtl/pipe_cla_sub_32_if.sv
// Operand/result handshake bundle for pipe_cla_sub_32.
interface pipe_cla_sub_32_if
  import pipe_cla_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/cla_nbit.sv
// Combinational N-bit carry-look-ahead adder built from bit generate/propagate terms.
module cla_nbit #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   carry;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flattened lookahead sum of products, not a ripple chain.
  always_comb begin
    logic cc;
    logic pp;
    cc       = 1'b0;
    pp       = 1'b1;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      cc = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      carry[i+1] = cc | (pp & cin);
    end
  end

  assign sum  = p ^ carry[N-1:0];
  assign cout = carry[N];
endmodule

// File: rtl/pipe_cla_sub_32.sv
// Two-stage pipelined CLA subtractor (diff = a - b - bin) with valid/ready on both sides.
// Define PIPE_CLA_SUB_SAT_EN to saturate diff on signed overflow.
module pipe_cla_sub_32
  import pipe_cla_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic              clk,
  input logic              rst,
  pipe_cla_sub_32_if.slave bus
);
  localparam int unsigned HALF = WIDTH / 2;

  logic             s1_valid_q;
  logic [HALF-1:0]  lo_q;
  logic             c_mid_q;
  logic [HALF-1:0]  a_hi_q;
  logic [HALF-1:0]  b_hi_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             s2_ready;
  logic             in_ready;
  logic             in_fire;
  logic [HALF-1:0]  lo_sum;
  logic             lo_cout;
  logic [HALF-1:0]  hi_sum;
  logic             hi_cout;
  logic [WIDTH-1:0] diff_d;
  logic             bout_d;
  logic             ovf_d;

  assign s2_ready = ~out_valid_q | bus.out_ready;
  assign in_ready = ~s1_valid_q | s2_ready;
  assign in_fire  = bus.in_valid & in_ready;

  // Subtraction as a + ~b + ~bin; the low-half carry hands the borrow to stage 2.
  cla_nbit #(.N(HALF)) u_cla_lo (
    .a    (bus.a[HALF-1:0]),
    .b    (~bus.b[HALF-1:0]),
    .cin  (~bus.bin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_nbit #(.N(HALF)) u_cla_hi (
    .a    (a_hi_q),
    .b    (~b_hi_q),
    .cin  (c_mid_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin
    bout_d = ~hi_cout;
    ovf_d  = (a_hi_q[HALF-1] != b_hi_q[HALF-1]) & (hi_sum[HALF-1] != a_hi_q[HALF-1]);
`ifdef PIPE_CLA_SUB_SAT_EN
    if (ovf_d) begin
      diff_d = a_hi_q[HALF-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      diff_d = {hi_sum, lo_q};
    end
`else
    diff_d = {hi_sum, lo_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_q        <= '0;
      c_mid_q     <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        lo_q       <= lo_sum;
        c_mid_q    <= lo_cout;
        a_hi_q     <= bus.a[WIDTH-1:HALF];
        b_hi_q     <= bus.b[WIDTH-1:HALF];
      end else if (s2_ready) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_ready) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          diff_q <= diff_d;
          bout_q <= bout_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_cla_sub_32.sv
// Self-checking bench for pipe_cla_sub_32 against an arithmetic reference model.
module tb_pipe_cla_sub_32;
  import pipe_cla_pkg::*;

  localparam int unsigned W = DefaultWidth;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pipe_cla_sub_32_if #(.WIDTH(W)) bus ();

  pipe_cla_sub_32 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic bin);
    res_t       r;
    logic [W:0] wide;
    longint     s;
    longint     lim;
    wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    lim  = longint'(1) << (W - 1);
    r.d  = wide[W-1:0];
    r.bo = wide[W];
    r.ov = (s > lim - 1) || (s < -lim);
`ifdef PIPE_CLA_SUB_SAT_EN
    if (r.ov) r.d = a[W-1] ? SatMin : SatMax;
`endif
    return r;
  endfunction

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run += 5;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    if (bus.diff !== '0) begin
      tests_failed++; $display("FAIL reset_diff: got %h want 0", bus.diff);
    end
    if (bus.bout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_bout: got %b want 0", bus.bout);
    end
    if (bus.ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    end
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic         vbin[4];
    logic [W-1:0] ed[4];
    logic         ebo[4];
    logic         eov[4];
    va[0] = 32'h0000_0010; vb[0] = 32'h0000_0003; vbin[0] = 1'b0;
    ed[0] = 32'h0000_000D; ebo[0] = 1'b0; eov[0] = 1'b0;
    va[1] = 32'h0000_0000; vb[1] = 32'h0000_0001; vbin[1] = 1'b1;
    ed[1] = 32'hFFFF_FFFE; ebo[1] = 1'b1; eov[1] = 1'b0;
    va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001; vbin[2] = 1'b0;
`ifdef PIPE_CLA_SUB_SAT_EN
    ed[2] = 32'h8000_0000;
`else
    ed[2] = 32'h7FFF_FFFF;
`endif
    ebo[2] = 1'b0; eov[2] = 1'b1;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vbin[3] = 1'b1;
    ed[3] = 32'hFFFF_FFFF; ebo[3] = 1'b1; eov[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = va[k]; bus.b = vb[k]; bus.bin = vbin[k];
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL dir%0d_in_ready: got %b want 1", k, bus.in_ready);
      end
      @(negedge clk);
      idle();
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL dir%0d_early_valid: got %b want 0", k, bus.out_valid);
      end
      @(negedge clk);
      #1;
      tests_run += 4;
      if (bus.out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL dir%0d_latency: got %b want 1", k, bus.out_valid);
      end
      if (bus.diff !== ed[k]) begin
        tests_failed++; $display("FAIL dir%0d_diff: got %h want %h", k, bus.diff, ed[k]);
      end
      if (bus.bout !== ebo[k]) begin
        tests_failed++; $display("FAIL dir%0d_bout: got %b want %b", k, bus.bout, ebo[k]);
      end
      if (bus.ovf !== eov[k]) begin
        tests_failed++; $display("FAIL dir%0d_ovf: got %b want %b", k, bus.ovf, eov[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'h0000_0100; bus.b = 32'h0000_0001; bus.bin = 1'b0;
    @(negedge clk);
    bus.a = 32'h0000_0200; bus.b = 32'h0000_0002;
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 32'h0000_00FF) begin
      tests_failed++;
      $display("FAIL midflight_pre: got valid=%b diff=%h want valid=1 diff=000000ff",
               bus.out_valid, bus.diff);
    end
    // Offer a third beat while reset is asserted; it must be ignored.
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.a = 32'h0000_0300;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    tests_run += 4;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midflight_valid: got %b want 0", bus.out_valid);
    end
    if (bus.diff !== '0) begin
      tests_failed++; $display("FAIL midflight_diff: got %h want 0", bus.diff);
    end
    if (bus.bout !== 1'b0) begin
      tests_failed++; $display("FAIL midflight_bout: got %b want 0", bus.bout);
    end
    if (bus.ovf !== 1'b0) begin
      tests_failed++; $display("FAIL midflight_ovf: got %b want 0", bus.ovf);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL midflight_ghost%0d: got %b want 0", c, bus.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t         q[$];
    res_t         exp_r;
    res_t         held;
    logic         stalled = 1'b0;
    logic         pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    logic [W-1:0] ra = W'($urandom);
    logic [W-1:0] rb = W'($urandom);
    logic         rbin = 1'($urandom);
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = pat[cyc % 6];
      bus.in_valid  = (sent < 8);
      bus.a = ra; bus.b = rb; bus.bin = rbin;
      #1;
      if (stalled) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || {bus.diff, bus.bout, bus.ovf} !== held) begin
          tests_failed++;
          $display("FAIL bp_stall_stable: got v=%b %h/%b/%b want v=1 %h/%b/%b", bus.out_valid,
                   bus.diff, bus.bout, bus.ovf, held.d, held.bo, held.ov);
        end
      end
      tests_run++;
      if (bus.in_ready !== !(q.size() == 2 && !bus.out_ready)) begin
        tests_failed++;
        $display("FAIL bp_in_ready: got %b want %b (in flight %0d)", bus.in_ready,
                 !(q.size() == 2 && !bus.out_ready), q.size());
      end
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++; $display("FAIL bp_extra_beat: got diff=%h want none", bus.diff);
        end else begin
          exp_r = q.pop_front();
          got++;
          if ({bus.diff, bus.bout, bus.ovf} !== exp_r) begin
            tests_failed++;
            $display("FAIL bp_result%0d: got %h/%b/%b want %h/%b/%b", got, bus.diff, bus.bout,
                     bus.ovf, exp_r.d, exp_r.bo, exp_r.ov);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ra, rb, rbin));
        sent++;
        ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = {bus.diff, bus.bout, bus.ovf};
      cyc++;
    end
    tests_run++;
    if (got != 8 || q.size() != 0) begin
      tests_failed++; $display("FAIL bp_count: got %0d beats want 8 (left %0d)", got, q.size());
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    res_t         q[$];
    res_t         exp_r;
    logic         started = 1'b0;
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    logic [W-1:0] ra = W'($urandom);
    logic [W-1:0] rb = W'($urandom);
    logic         rbin = 1'($urandom);
    while (got < 16 && cyc < 100) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 16);
      bus.a = ra; bus.b = rb; bus.bin = rbin;
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready);
      end
      if (started) begin
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
          tests_failed++; $display("FAIL b2b_bubble: got out_valid=%b want 1 at beat %0d",
                                   bus.out_valid, got);
        end
      end
      if (bus.out_valid) begin
        started = 1'b1;
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++; $display("FAIL b2b_extra_beat: got diff=%h want none", bus.diff);
        end else begin
          exp_r = q.pop_front();
          got++;
          if ({bus.diff, bus.bout, bus.ovf} !== exp_r) begin
            tests_failed++;
            $display("FAIL b2b_result%0d: got %h/%b/%b want %h/%b/%b", got, bus.diff, bus.bout,
                     bus.ovf, exp_r.d, exp_r.bo, exp_r.ov);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ra, rb, rbin));
        sent++;
        ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      end
      cyc++;
    end
    tests_run++;
    if (got != 16) begin
      tests_failed++; $display("FAIL b2b_count: got %0d beats want 16", got);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midflight();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
